writeback_queue: RTL and testbench

- Parametrised multi-producer, multi-consumer writeback queue between the arithmetic/store units and register-file write ports.
- Each cycle it compacts any subset of NUM_ARITH arithmetic and NUM_STORE store writebacks into a circular buffer and drains up to NUM_DEQ entries in FIFO order.
- Adds occupancy tracking, full/empty handling, producer backpressure, per-lane last-status forwarding for stores, and synchronous reset.

---
 rtl/wbq_pkg.sv | 24 ++
 rtl/wbq_compactor.sv | 25 ++
 rtl/writeback_queue.sv | 202 ++++++++++++++++++++
 tb/tb_writeback_queue.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wbq_pkg.sv
// Shared definitions for the writeback queue: default field widths, the
// default entry layout and small helpers used by the queue and its compactor.
package wbq_pkg;

  localparam int ADDR_W        = 5;
  localparam int DATA_W        = 16;
  localparam int STATUS_W      = 2;
  localparam int DEF_NUM_ARITH = 2;
  localparam int DEF_NUM_STORE = 2;
  localparam int NUM_IN        = DEF_NUM_ARITH + DEF_NUM_STORE;

  // One queued writeback at the default widths.
  typedef struct packed {
    logic [ADDR_W-1:0]   address;
    logic [DATA_W-1:0]   data;
    logic [STATUS_W-1:0] status;
  } wbq_entry_t;

  // Smaller of two integers, used to bound the per-cycle dequeue count.
  function automatic int wbq_min(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

endpackage

// File: rtl/wbq_compactor.sv
// Combinational prefix popcount: for every input lane, how many enabled lanes
// precede it (its slot offset from tail), plus the total number enabled.
module wbq_compactor #(
  parameter int N_IN  = 4,
  parameter int OFF_W = $clog2(N_IN + 1)
) (
  input  logic [N_IN-1:0]       en_i,
  output logic [N_IN*OFF_W-1:0] offset_o,
  output logic [OFF_W-1:0]      n_enq_o
);
  import wbq_pkg::*;

  // Running sum over the lanes in compaction order.
  always_comb begin
    logic [OFF_W-1:0] run;
    run      = '0;
    offset_o = '0;
    for (int j = 0; j < N_IN; j++) begin
      offset_o[j*OFF_W +: OFF_W] = run;
      run = run + OFF_W'(en_i[j]);
    end
    n_enq_o = run;
  end

endmodule

// File: rtl/writeback_queue.sv
// Multi-producer / multi-consumer writeback queue. Arithmetic and store
// writebacks are compacted into a circular buffer each cycle and up to
// NUM_DEQ entries drain in FIFO order onto registered output lanes.
// Store entries take their status from the arithmetic lane (k mod NUM_ARITH),
// either live in the same cycle or from the last status that lane wrote.
// Optional: define WBQ_OVERFLOW_FLAG_EN to add a sticky overflow_o flag that
// records any enqueue attempt made while ready_o is low.
module writeback_queue #(
  parameter int NUM_ARITH = wbq_pkg::DEF_NUM_ARITH,
  parameter int NUM_STORE = wbq_pkg::DEF_NUM_STORE,
  parameter int NUM_DEQ   = 2,
  parameter int DEPTH     = 8,
  parameter int ADDR_W    = wbq_pkg::ADDR_W,
  parameter int DATA_W    = wbq_pkg::DATA_W,
  parameter int STATUS_W  = wbq_pkg::STATUS_W
) (
  input  logic                          clock_i,
  input  logic                          reset_i,
  input  logic [NUM_ARITH-1:0]          arithEnable_i,
  input  logic [NUM_ARITH*ADDR_W-1:0]   arithAddress_i,
  input  logic [NUM_ARITH*DATA_W-1:0]   arithData_i,
  input  logic [NUM_ARITH*STATUS_W-1:0] arithStatus_i,
  input  logic [NUM_STORE-1:0]          storeEnable_i,
  input  logic [NUM_STORE*ADDR_W-1:0]   storeAddress_i,
  input  logic [NUM_STORE*DATA_W-1:0]   storeData_i,
  output logic                          ready_o,
  output logic [NUM_DEQ-1:0]            enable_o,
  output logic [NUM_DEQ*ADDR_W-1:0]     address_o,
  output logic [NUM_DEQ*DATA_W-1:0]     data_o,
  output logic [NUM_DEQ*STATUS_W-1:0]   status_o,
  output logic [$clog2(DEPTH):0]        count_o
`ifdef WBQ_OVERFLOW_FLAG_EN
  ,
  output logic                          overflow_o
`endif
);
  import wbq_pkg::*;

  localparam int N_IN  = NUM_ARITH + NUM_STORE;
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int OFF_W = $clog2(N_IN + 1);

  // Pointer / occupancy state
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] n_deq;

  // Per-arith-lane status remembered for later store-only cycles
  logic [STATUS_W-1:0] last_status_q [NUM_ARITH];

  // Inputs flattened into compaction order (arith lanes, then store lanes)
  logic [N_IN-1:0]     in_en;
  logic [ADDR_W-1:0]   in_addr   [N_IN];
  logic [DATA_W-1:0]   in_data   [N_IN];
  logic [STATUS_W-1:0] in_status [N_IN];

  // Compaction results
  logic [N_IN*OFF_W-1:0] offset;
  logic [OFF_W-1:0]      n_enq;
  logic [OFF_W-1:0]      n_enq_acc;
  logic [PTR_W-1:0]      wr_slot [N_IN];
  logic [PTR_W-1:0]      rd_slot [NUM_DEQ];

  // Entry storage; written only on accepted cycles, contents need no reset
  logic [ADDR_W-1:0]   mem_addr_q   [DEPTH];
  logic [DATA_W-1:0]   mem_data_q   [DEPTH];
  logic [STATUS_W-1:0] mem_status_q [DEPTH];

  // Registered output lanes
  logic [NUM_DEQ-1:0]  out_en_q;
  logic [ADDR_W-1:0]   out_addr_q   [NUM_DEQ];
  logic [DATA_W-1:0]   out_data_q   [NUM_DEQ];
  logic [STATUS_W-1:0] out_status_q [NUM_DEQ];

  assign in_en = {storeEnable_i, arithEnable_i};

  for (genvar gi = 0; gi < NUM_ARITH; gi++) begin : g_arith_in
    assign in_addr[gi]   = arithAddress_i[gi*ADDR_W +: ADDR_W];
    assign in_data[gi]   = arithData_i[gi*DATA_W +: DATA_W];
    assign in_status[gi] = arithStatus_i[gi*STATUS_W +: STATUS_W];
  end

  for (genvar gi = 0; gi < NUM_STORE; gi++) begin : g_store_in
    localparam int A = gi % NUM_ARITH;
    assign in_addr[NUM_ARITH+gi] = storeAddress_i[gi*ADDR_W +: ADDR_W];
    assign in_data[NUM_ARITH+gi] = storeData_i[gi*DATA_W +: DATA_W];
    // Live status wins over the remembered one when the paired arith lane fires
    assign in_status[NUM_ARITH+gi] = arithEnable_i[A]
                                   ? arithStatus_i[A*STATUS_W +: STATUS_W]
                                   : last_status_q[A];
  end

  wbq_compactor #(
    .N_IN  (N_IN),
    .OFF_W (OFF_W)
  ) u_compactor (
    .en_i     (in_en),
    .offset_o (offset),
    .n_enq_o  (n_enq)
  );

  // All-or-nothing admission: room for every lane regardless of enables
  assign ready_o   = (count_q <= CNT_W'(DEPTH - N_IN));
  assign n_enq_acc = ready_o ? n_enq : '0;

  for (genvar gi = 0; gi < N_IN; gi++) begin : g_wr_slot
    assign wr_slot[gi] = tail_q + PTR_W'(offset[gi*OFF_W +: OFF_W]);
  end

  for (genvar gi = 0; gi < NUM_DEQ; gi++) begin : g_rd_slot
    assign rd_slot[gi] = head_q + PTR_W'(gi);
  end

  // Next-state pointers and occupancy; dequeue uses the pre-edge count only
  always_comb begin
    n_deq   = CNT_W'(wbq_min(int'(count_q), NUM_DEQ));
    head_d  = head_q + PTR_W'(n_deq);
    tail_d  = tail_q + PTR_W'(n_enq_acc);
    count_d = count_q + CNT_W'(n_enq_acc) - n_deq;
  end

  // Pointer and occupancy registers
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Write each enabled input into its compacted slot; groups may straddle the wrap
  always_ff @(posedge clock_i) begin
    if (!reset_i && ready_o) begin
      for (int j = 0; j < N_IN; j++) begin
        if (in_en[j]) begin
          mem_addr_q[wr_slot[j]]   <= in_addr[j];
          mem_data_q[wr_slot[j]]   <= in_data[j];
          mem_status_q[wr_slot[j]] <= in_status[j];
        end
      end
    end
  end

  for (genvar gi = 0; gi < NUM_ARITH; gi++) begin : g_last_status
    // Remember the status of every accepted arith writeback on this lane
    always_ff @(posedge clock_i) begin
      if (reset_i) begin
        last_status_q[gi] <= '0;
      end else if (ready_o && arithEnable_i[gi]) begin
        last_status_q[gi] <= arithStatus_i[gi*STATUS_W +: STATUS_W];
      end
    end
  end

  for (genvar gi = 0; gi < NUM_DEQ; gi++) begin : g_out
    // Registered read of entry head+gi; idle lanes keep their last payload
    always_ff @(posedge clock_i) begin
      if (reset_i) begin
        out_en_q[gi]     <= 1'b0;
        out_addr_q[gi]   <= '0;
        out_data_q[gi]   <= '0;
        out_status_q[gi] <= '0;
      end else if (CNT_W'(gi) < n_deq) begin
        out_en_q[gi]     <= 1'b1;
        out_addr_q[gi]   <= mem_addr_q[rd_slot[gi]];
        out_data_q[gi]   <= mem_data_q[rd_slot[gi]];
        out_status_q[gi] <= mem_status_q[rd_slot[gi]];
      end else begin
        out_en_q[gi]     <= 1'b0;
      end
    end

    assign address_o[gi*ADDR_W +: ADDR_W]     = out_addr_q[gi];
    assign data_o[gi*DATA_W +: DATA_W]        = out_data_q[gi];
    assign status_o[gi*STATUS_W +: STATUS_W]  = out_status_q[gi];
  end

  assign enable_o = out_en_q;
  assign count_o  = count_q;

`ifdef WBQ_OVERFLOW_FLAG_EN
  logic overflow_q;

  // Sticky record of a producer pushing while the queue refused it
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      overflow_q <= 1'b0;
    end else if (!ready_o && (|in_en)) begin
      overflow_q <= 1'b1;
    end
  end

  assign overflow_o = overflow_q;
`endif

endmodule

// File: tb/tb_writeback_queue.sv
// Scoreboard bench for writeback_queue: stimulus pushes expected entries,
// a negedge monitor pops and compares whatever the output lanes present.
module tb_writeback_queue;

  typedef struct packed {
    logic [4:0]  addr;
    logic [15:0] data;
    logic [1:0]  stat;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  a_en;
  logic [9:0]  a_addr;
  logic [31:0] a_data;
  logic [3:0]  a_stat;
  logic [1:0]  s_en;
  logic [9:0]  s_addr;
  logic [31:0] s_data;
  logic        ready;
  logic [1:0]  en_o;
  logic [9:0]  addr_o;
  logic [31:0] data_o;
  logic [3:0]  stat_o;
  logic [3:0]  cnt;
`ifdef WBQ_OVERFLOW_FLAG_EN
  logic        ovf;
`endif

  int   tests = 0;
  int   fails = 0;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  writeback_queue dut (
    .clock_i        (clk),
    .reset_i        (rst),
    .arithEnable_i  (a_en),
    .arithAddress_i (a_addr),
    .arithData_i    (a_data),
    .arithStatus_i  (a_stat),
    .storeEnable_i  (s_en),
    .storeAddress_i (s_addr),
    .storeData_i    (s_data),
    .ready_o        (ready),
    .enable_o       (en_o),
    .address_o      (addr_o),
    .data_o         (data_o),
    .status_o       (stat_o),
    .count_o        (cnt)
`ifdef WBQ_OVERFLOW_FLAG_EN
    ,
    .overflow_o     (ovf)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  task automatic arith(input int l, input logic [4:0] ad, input logic [15:0] d, input logic [1:0] st);
    a_en[l]          = 1'b1;
    a_addr[l*5 +: 5]   = ad;
    a_data[l*16 +: 16] = d;
    a_stat[l*2 +: 2]   = st;
  endtask

  task automatic store(input int l, input logic [4:0] ad, input logic [15:0] d);
    s_en[l]            = 1'b1;
    s_addr[l*5 +: 5]   = ad;
    s_data[l*16 +: 16] = d;
  endtask

  task automatic push(input logic [4:0] ad, input logic [15:0] d, input logic [1:0] st);
    exp_t e;
    e.addr = ad;
    e.data = d;
    e.stat = st;
    exp_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    a_en = '0;
    s_en = '0;
  endtask

  // Monitor: every valid output lane must match the oldest expected entry
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        if (en_o[i] === 1'b1) begin
          tests++;
          if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL lane%0d_unexpected: got addr=%0d data=0x%0h status=%0d, required no output",
                     i, addr_o[i*5 +: 5], data_o[i*16 +: 16], stat_o[i*2 +: 2]);
          end else begin
            e = exp_q.pop_front();
            if ({addr_o[i*5 +: 5], data_o[i*16 +: 16], stat_o[i*2 +: 2]} !== e) begin
              fails++;
              $display("FAIL lane%0d_entry: got addr=%0d data=0x%0h status=%0d, required addr=%0d data=0x%0h status=%0d",
                       i, addr_o[i*5 +: 5], data_o[i*16 +: 16], stat_o[i*2 +: 2], e.addr, e.data, e.stat);
            end else begin
              $display("[TB] t=%0t lane%0d addr=%0d data=0x%0h status=%0d ok",
                       $time, i, e.addr, e.data, e.stat);
            end
          end
        end
      end
    end
  end

  initial begin
    rst    = 1'b1;
    a_en   = '0; a_addr = '0; a_data = '0; a_stat = '0;
    s_en   = '0; s_addr = '0; s_data = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state
    check("rst_count", 32'(cnt), 0);
    check("rst_enable", 32'(en_o), 0);
    check("rst_address", 32'(addr_o), 0);
    check("rst_data", data_o, 0);
    check("rst_status", 32'(stat_o), 0);
    check("rst_ready", 32'(ready), 1);
`ifdef WBQ_OVERFLOW_FLAG_EN
    check("rst_overflow", 32'(ovf), 0);
`endif

    // Two arith lanes; no same-cycle bypass, drained on the following edge
    arith(0, 5'd3, 16'h1111, 2'b01);
    arith(1, 5'd7, 16'h2222, 2'b10);
    push(5'd3, 16'h1111, 2'b01);
    push(5'd7, 16'h2222, 2'b10);
    tick();
    check("t1_count_after_enq", 32'(cnt), 2);
    check("t1_no_bypass", 32'(en_o), 0);
    tick();
    check("t1_enable", 32'(en_o), 2'b11);
    check("t1_addresses", 32'(addr_o), {5'd7, 5'd3});
    check("t1_count_empty", 32'(cnt), 0);
    tick();
    check("t1_idle_enable", 32'(en_o), 0);

    // Store lane 1 alone picks up arith lane 1's remembered status
    store(1, 5'd9, 16'hBEEF);
    push(5'd9, 16'hBEEF, 2'b10);
    tick();
    tick();
    check("t2_enable_one", 32'(en_o), 2'b01);
    check("t2_lane1_hold", 32'(data_o[31:16]), 16'h2222);
    tick();

    // Store lane 1 with arith lane 1 live in the same cycle
    arith(1, 5'd12, 16'h3333, 2'b11);
    store(1, 5'd10, 16'hCAFE);
    push(5'd12, 16'h3333, 2'b11);
    push(5'd10, 16'hCAFE, 2'b11);
    tick();
    tick();
    check("t2b_enable", 32'(en_o), 2'b11);
    tick();

    // All four lanes two cycles in a row, then a refused third attempt
    arith(0, 5'd1, 16'hA001, 2'b00);
    arith(1, 5'd2, 16'hA002, 2'b01);
    store(0, 5'd3, 16'hA003);
    store(1, 5'd4, 16'hA004);
    push(5'd1, 16'hA001, 2'b00); push(5'd2, 16'hA002, 2'b01);
    push(5'd3, 16'hA003, 2'b00); push(5'd4, 16'hA004, 2'b01);
    tick();
    check("t3_count4", 32'(cnt), 4);
    check("t3_ready_at4", 32'(ready), 1);
    arith(0, 5'd5, 16'hB005, 2'b10);
    arith(1, 5'd6, 16'hB006, 2'b11);
    store(0, 5'd7, 16'hB007);
    store(1, 5'd8, 16'hB008);
    push(5'd5, 16'hB005, 2'b10); push(5'd6, 16'hB006, 2'b11);
    push(5'd7, 16'hB007, 2'b10); push(5'd8, 16'hB008, 2'b11);
    tick();
    check("t3_count6", 32'(cnt), 6);
    check("t3_ready_low", 32'(ready), 0);
    arith(0, 5'd30, 16'hDEAD, 2'b01);
    arith(1, 5'd31, 16'hDEAD, 2'b00);
    store(0, 5'd29, 16'hDEAD);
    store(1, 5'd28, 16'hDEAD);
    tick();
    check("t3_refused_count", 32'(cnt), 4);
`ifdef WBQ_OVERFLOW_FLAG_EN
    check("t3_overflow_set", 32'(ovf), 1);
`endif
    tick();
    check("t3_count2", 32'(cnt), 2);
    tick();
    check("t3_count0", 32'(cnt), 0);
    tick();
    check("t3_idle_enable", 32'(en_o), 0);

    // Refused cycle must not have changed the remembered status of lane 0
    store(0, 5'd20, 16'h5555);
    push(5'd20, 16'h5555, 2'b10);
    tick();
    tick();
    check("t3b_enable", 32'(en_o), 2'b01);
    tick();

    // Five entries drain 2,2,1 with lane 1 held on the last cycle
    arith(0, 5'd11, 16'h4001, 2'b01);
    arith(1, 5'd12, 16'h4002, 2'b00);
    store(0, 5'd13, 16'h4003);
    store(1, 5'd14, 16'h4004);
    push(5'd11, 16'h4001, 2'b01); push(5'd12, 16'h4002, 2'b00);
    push(5'd13, 16'h4003, 2'b01); push(5'd14, 16'h4004, 2'b00);
    tick();
    check("t4_count4", 32'(cnt), 4);
    store(0, 5'd15, 16'h4005);
    push(5'd15, 16'h4005, 2'b01);
    tick();
    check("t4_drain1_enable", 32'(en_o), 2'b11);
    check("t4_count3", 32'(cnt), 3);
    tick();
    check("t4_drain2_enable", 32'(en_o), 2'b11);
    check("t4_count1", 32'(cnt), 1);
    tick();
    check("t4_drain3_enable", 32'(en_o), 2'b01);
    check("t4_count0", 32'(cnt), 0);
    check("t4_lane1_data_hold", 32'(data_o[31:16]), 16'h4004);
    check("t4_lane1_addr_hold", 32'(addr_o[9:5]), 5'd14);
    tick();
    check("t4_empty_enable", 32'(en_o), 0);

    // Sparse compaction: arith1, store0 (remembered), store1 (live); tail ends at 6
    arith(1, 5'd21, 16'h6001, 2'b10);
    store(0, 5'd22, 16'h6002);
    store(1, 5'd23, 16'h6003);
    push(5'd21, 16'h6001, 2'b10);
    push(5'd22, 16'h6002, 2'b01);
    push(5'd23, 16'h6003, 2'b10);
    tick();
    check("t5_count3", 32'(cnt), 3);
    tick();
    tick();
    check("t5_count0", 32'(cnt), 0);
    tick();

    // Group straddling the wrap: slots 6,7,0,1
    arith(0, 5'd24, 16'h7001, 2'b11);
    arith(1, 5'd25, 16'h7002, 2'b00);
    store(0, 5'd26, 16'h7003);
    store(1, 5'd27, 16'h7004);
    push(5'd24, 16'h7001, 2'b11); push(5'd25, 16'h7002, 2'b00);
    push(5'd26, 16'h7003, 2'b11); push(5'd27, 16'h7004, 2'b00);
    tick();
    check("t6_count4", 32'(cnt), 4);
    tick();
    check("t6_wrap_addr_a", 32'(addr_o), {5'd25, 5'd24});
    tick();
    check("t6_wrap_addr_b", 32'(addr_o), {5'd27, 5'd26});
    check("t6_count0", 32'(cnt), 0);
    tick();
    check("t6_scoreboard_drained", exp_q.size(), 0);

    // Reset with five entries queued and enables asserted in the reset cycle
    arith(0, 5'd1, 16'h8001, 2'b01);
    arith(1, 5'd2, 16'h8002, 2'b10);
    store(0, 5'd3, 16'h8003);
    store(1, 5'd4, 16'h8004);
    push(5'd1, 16'h8001, 2'b01); push(5'd2, 16'h8002, 2'b10);
    push(5'd3, 16'h8003, 2'b01); push(5'd4, 16'h8004, 2'b10);
    tick();
    arith(0, 5'd5, 16'h8005, 2'b11);
    arith(1, 5'd6, 16'h8006, 2'b00);
    store(0, 5'd7, 16'h8007);
    push(5'd5, 16'h8005, 2'b11); push(5'd6, 16'h8006, 2'b00);
    push(5'd7, 16'h8007, 2'b11);
    tick();
    check("t7_count5", 32'(cnt), 5);
`ifdef WBQ_OVERFLOW_FLAG_EN
    check("t7_overflow_sticky", 32'(ovf), 1);
`endif
    rst = 1'b1;
    arith(0, 5'd9, 16'h9999, 2'b01);
    arith(1, 5'd9, 16'h9999, 2'b01);
    store(0, 5'd9, 16'h9999);
    store(1, 5'd9, 16'h9999);
    @(negedge clk);
    check("t7_pending_before_rst", exp_q.size(), 5);
    tick();
    exp_q.delete();
    rst = 1'b0;
    check("t7_rst_count", 32'(cnt), 0);
    check("t7_rst_enable", 32'(en_o), 0);
    check("t7_rst_address", 32'(addr_o), 0);
    check("t7_rst_data", data_o, 0);
    check("t7_rst_ready", 32'(ready), 1);
`ifdef WBQ_OVERFLOW_FLAG_EN
    check("t7_rst_overflow", 32'(ovf), 0);
`endif
    tick();
    check("t7_post_count", 32'(cnt), 0);
    check("t7_post_enable", 32'(en_o), 0);
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
